// File: rtl/pe_array_stripe_ctrl_pkg.sv
// pe_ctrl_pkg: shared state, init-state and direction encodings for the PE array controller
package pe_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_PARAM,
        S_PRIME,
        S_STREAM,
        S_DRAIN,
        S_WAIT_TB,
        S_DONE
    } state_t;
    localparam logic [1:0] INIT_H = 2'd0;
    localparam logic [1:0] INIT_D = 2'd1;
    localparam logic [1:0] INIT_I = 2'd2;
    localparam logic [1:0] INIT_NONE = 2'd3;
    localparam logic [2:0] NU_DONT_CARE = 3'd5;
    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_DIAG = 2'd1;
    localparam logic [1:0] DIR_UP = 2'd2;
    localparam logic [1:0] DIR_LEFT = 2'd3;
endpackage

// File: rtl/pe_array_stripe_ctrl_stripe_counter.sv
// stripe_counter: stripe index with its base row, per-PE row-valid mask and last-stripe flag
module stripe_counter #(
    parameter int NUM_PE = 4,
    parameter int LOG_NUM_PE = $clog2(NUM_PE),
    parameter int QUERY_LEN_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       inc,
    input  logic [QUERY_LEN_WIDTH-1:0] query_len,
    output logic [QUERY_LEN_WIDTH-1:0] stripe,
    output logic [QUERY_LEN_WIDTH-1:0] base,
    output logic [NUM_PE-1:0]          rows_valid,
    output logic                       last
);
    localparam int EW = QUERY_LEN_WIDTH + LOG_NUM_PE + 1;
    logic [EW-1:0] base_w;
    always_ff @(posedge clk) begin
        if (rst || clear) stripe <= '0;
        else if (inc) stripe <= stripe + 1'b1;
    end
    assign base_w = EW'(stripe) * EW'(NUM_PE);
    assign base = base_w[QUERY_LEN_WIDTH-1:0];
    assign last = (base_w + EW'(NUM_PE)) >= EW'(query_len);
    for (genvar k = 0; k < NUM_PE; k++) begin : g_rv
        assign rows_valid[k] = (base_w + EW'(k)) < EW'(query_len);
    end
endmodule

// File: rtl/pe_array_stripe_ctrl.sv
// pe_array_stripe_ctrl: loads PE parameters, then streams the reference through PE0 once per query stripe
module pe_array_stripe_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_PE = 4,
    parameter int LOG_NUM_PE = $clog2(NUM_PE),
    parameter int REF_LEN_WIDTH = 10,
    parameter int QUERY_LEN_WIDTH = 10,
    parameter int LOG_MAX_TILE_SIZE = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [REF_LEN_WIDTH-1:0]     ref_len,
    input  logic [QUERY_LEN_WIDTH-1:0]   query_len,
    input  logic [1:0]                   init_state_in,
    input  logic [LOG_MAX_TILE_SIZE:0]   marker_in,
    input  logic                         tb_ready,
    input  logic [2:0]                   ref_rd_data,
    output logic                         ref_rd_en,
    output logic [REF_LEN_WIDTH-1:0]     ref_rd_addr,
    output logic                         set_param,
    output logic                         param_valid,
    output logic                         pe_init,
    output logic [2:0]                   pe_ref,
    output logic [REF_LEN_WIDTH-1:0]     pe_ref_idx,
    output logic [QUERY_LEN_WIDTH-1:0]   pe_query_idx,
    output logic                         pe_block,
    output logic [1:0]                   pe_init_state,
    output logic [LOG_MAX_TILE_SIZE:0]   pe_marker,
    output logic [NUM_PE-1:0]            rows_valid,
    output logic                         stripe_start,
    output logic                         stripe_done,
    output logic                         busy,
    output logic                         done
);
    localparam int DRAIN_CYC = NUM_PE > 1 ? NUM_PE - 1 : 1;
    localparam int DW = $clog2(DRAIN_CYC + 1);
    state_t state, nxt;
    logic [REF_LEN_WIDTH-1:0] rl_q, col;
    logic [QUERY_LEN_WIDTH-1:0] ql_q, stripe, base;
    logic [1:0] is_q;
    logic [LOG_MAX_TILE_SIZE:0] mk_q;
    logic [DW-1:0] dcnt;
    logic [NUM_PE-1:0] rv;
    logic param_seen, last, start_ok, stream_end, drain_end, more;
    assign start_ok = start && ref_len != '0 && query_len != '0;
    assign stream_end = col == rl_q - 1'b1;
    assign drain_end = dcnt == DW'(DRAIN_CYC - 1);
    assign more = ({1'b0, col} + 1'b1) < {1'b0, rl_q};
    stripe_counter #(
        .NUM_PE(NUM_PE),
        .LOG_NUM_PE(LOG_NUM_PE),
        .QUERY_LEN_WIDTH(QUERY_LEN_WIDTH)
    ) u_stripe (
        .clk(clk),
        .rst(rst),
        .clear(state == S_IDLE && start),
        .inc(state == S_DRAIN && drain_end && !last),
        .query_len(ql_q),
        .stripe(stripe),
        .base(base),
        .rows_valid(rv),
        .last(last)
    );
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = start ? (start_ok ? S_PARAM : S_DONE) : S_IDLE;
            S_PARAM:   nxt = S_PRIME;
            S_PRIME:   nxt = S_STREAM;
            S_STREAM:  nxt = stream_end ? S_DRAIN : S_STREAM;
            S_DRAIN:   nxt = !drain_end ? S_DRAIN : last ? S_DONE : tb_ready ? S_PRIME : S_WAIT_TB;
            S_WAIT_TB: nxt = tb_ready ? S_PRIME : S_WAIT_TB;
            S_DONE:    nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            col <= '0;
            dcnt <= '0;
            param_seen <= 1'b0;
            rl_q <= '0;
            ql_q <= '0;
            is_q <= '0;
            mk_q <= '0;
        end else begin
            state <= nxt;
            col <= state == S_STREAM ? col + 1'b1 : '0;
            dcnt <= state == S_DRAIN ? dcnt + 1'b1 : '0;
            param_seen <= state == S_PARAM || (param_seen && state != S_DONE);
            if (state == S_IDLE && start_ok) begin
                rl_q <= ref_len;
                ql_q <= query_len;
                is_q <= init_state_in;
                mk_q <= marker_in;
            end
        end
    end
    assign busy = state != S_IDLE;
    assign set_param = state == S_PARAM;
    assign param_valid = set_param || param_seen;
    assign pe_init = state == S_STREAM;
    assign ref_rd_en = state == S_PRIME || (pe_init && more);
    assign ref_rd_addr = (pe_init && more) ? col + 1'b1 : '0;
    assign pe_ref = pe_init ? ref_rd_data : 3'd0;
    assign pe_ref_idx = pe_init ? col : '0;
    assign pe_query_idx = param_valid ? base : '0;
    assign pe_block = param_valid && stripe != '0;
    assign pe_init_state = is_q;
    assign pe_marker = mk_q;
    assign rows_valid = param_valid ? rv : '0;
    assign stripe_start = pe_init && col == '0;
    assign stripe_done = state == S_DRAIN && drain_end;
    assign done = state == S_DONE;
endmodule
